// File: rtl/chaos_response_ctrl_pkg.sv
// Shared definitions for the chaos response controller: state encoding,
// severity level codes, default thresholds and small decode helpers.
package chaos_response_ctrl_pkg;

   localparam int unsigned HIST_DEPTH = 4;

   typedef enum logic [2:0] {
      ST_NORMAL   = 3'd0,
      ST_WATCH    = 3'd1,
      ST_THROTTLE = 3'd2,
      ST_FLUSH    = 3'd3,
      ST_COOLDOWN = 3'd4
   } chaos_state_e;

   localparam logic [1:0] LVL_NORMAL   = 2'd0;
   localparam logic [1:0] LVL_WATCH    = 2'd1;
   localparam logic [1:0] LVL_THROTTLE = 2'd2;
   localparam logic [1:0] LVL_FLUSH    = 2'd3;

   localparam logic [15:0] DEF_WATCH_TH    = 16'h0200;
   localparam logic [15:0] DEF_THROTTLE_TH = 16'h0400;
   localparam logic [15:0] DEF_FLUSH_TH    = 16'h0800;
   localparam logic [15:0] DEF_HYST        = 16'h0080;

   function automatic logic [1:0] state_level(input chaos_state_e s);
      logic [1:0] lvl;
      lvl = LVL_NORMAL;
      case (s)
         ST_WATCH:    lvl = LVL_WATCH;
         ST_THROTTLE: lvl = LVL_THROTTLE;
         ST_COOLDOWN: lvl = LVL_THROTTLE;
         ST_FLUSH:    lvl = LVL_FLUSH;
         default:     lvl = LVL_NORMAL;
      endcase
      return lvl;
   endfunction

   function automatic logic is_throttling(input chaos_state_e s);
      return (s == ST_THROTTLE) || (s == ST_COOLDOWN);
   endfunction

endpackage

// File: rtl/chaos_score_filter.sv
// Four-entry score history and unrounded moving average (sum >> 2).
module chaos_score_filter
   import chaos_response_ctrl_pkg::*;
#(
   parameter int unsigned SCORE_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] avg
);

   logic [SCORE_W-1:0] hist [HIST_DEPTH];
   logic [SCORE_W+1:0] sum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
      end else begin
         hist[0] <= score;
         for (int unsigned i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
      end
   end

   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) sum = sum + {2'b00, hist[i]};
   end

   assign avg = sum[SCORE_W+1:2];

endmodule

// File: rtl/chaos_response_ctrl.sv
// Chaos score consumer: smooths the score, classifies severity with hysteresis
// and drives throttle, stall and flush request/acknowledge countermeasures.
module chaos_response_ctrl
   import chaos_response_ctrl_pkg::*;
#(
   parameter int unsigned       SCORE_W         = 16,
   parameter logic [SCORE_W-1:0] WATCH_TH       = DEF_WATCH_TH,
   parameter logic [SCORE_W-1:0] THROTTLE_TH    = DEF_THROTTLE_TH,
   parameter logic [SCORE_W-1:0] FLUSH_TH       = DEF_FLUSH_TH,
   parameter logic [SCORE_W-1:0] HYST           = DEF_HYST,
   parameter int unsigned       PERSIST_CYC     = 4,
   parameter int unsigned       THROTTLE_PERIOD = 4,
   parameter int unsigned       COOLDOWN_CYC    = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [SCORE_W-1:0] chaos_score_in,
   input  logic               enable,
   input  logic               flush_ack,
   output logic               flush_req,
   output logic               stall_pipeline,
   output logic               throttle_stall,
   output logic [1:0]         chaos_level,
   output logic [7:0]         recovery_count
);

   localparam int unsigned PW = $clog2(PERSIST_CYC + 1);
   localparam int unsigned TW = $clog2(THROTTLE_PERIOD);
   localparam int unsigned CW = $clog2(COOLDOWN_CYC + 1);

   chaos_state_e    state, state_nx;
   logic [PW-1:0]   persist_cnt, persist_nx;
   logic [TW-1:0]   period_cnt, period_nx;
   logic [CW-1:0]   cool_cnt, cool_nx;
   logic [SCORE_W-1:0] avg;

   logic esc_cond, deesc_cond, escalate, flush_done;
   logic flush_nx, stall_nx, throttle_nx;
   logic [1:0] level_nx;
   logic [7:0] recovery_nx;

   chaos_score_filter #(.SCORE_W(SCORE_W)) u_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .score   (chaos_score_in),
      .avg     (avg)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_NORMAL;
         persist_cnt <= '0;
         period_cnt  <= '0;
         cool_cnt    <= '0;
      end else begin
         state       <= state_nx;
         persist_cnt <= persist_nx;
         period_cnt  <= period_nx;
         cool_cnt    <= cool_nx;
      end
   end

   always_comb begin
      esc_cond   = 1'b0;
      deesc_cond = 1'b0;
      case (state)
         ST_NORMAL:   esc_cond = (avg >= WATCH_TH);
         ST_WATCH: begin
            esc_cond   = (avg >= THROTTLE_TH);
            deesc_cond = (avg < (WATCH_TH - HYST));
         end
         ST_THROTTLE: begin
            esc_cond   = (avg >= FLUSH_TH);
            deesc_cond = (avg < (THROTTLE_TH - HYST));
         end
         default: ;
      endcase
      escalate   = esc_cond && (persist_cnt == PW'(PERSIST_CYC - 1));
      flush_done = (state == ST_FLUSH) && flush_ack && flush_req;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_NORMAL:
            if (enable && escalate) state_nx = ST_WATCH;
         ST_WATCH:
            if (!enable || deesc_cond) state_nx = ST_NORMAL;
            else if (escalate)         state_nx = ST_THROTTLE;
         ST_THROTTLE:
            if (!enable)         state_nx = ST_NORMAL;
            else if (deesc_cond) state_nx = ST_WATCH;
            else if (escalate)   state_nx = ST_FLUSH;
         // a disabled controller still finishes the handshake, skipping COOLDOWN
         ST_FLUSH:
            if (flush_done) state_nx = enable ? ST_COOLDOWN : ST_NORMAL;
         ST_COOLDOWN:
            if (!enable) state_nx = ST_NORMAL;
            else if (cool_cnt == CW'(COOLDOWN_CYC - 1))
               state_nx = (avg >= WATCH_TH) ? ST_WATCH : ST_NORMAL;
         default: state_nx = ST_NORMAL;
      endcase
   end

   always_comb begin
      persist_nx = (!enable || (state_nx != state) || !esc_cond) ? '0 : persist_cnt + PW'(1);
      cool_nx    = ((state == ST_COOLDOWN) && (state_nx == ST_COOLDOWN)) ? cool_cnt + CW'(1) : '0;
      period_nx  = '0;
      // period restarts at 0 on entry, so the first pulse lands one cycle later
      if ((state_nx == state) && is_throttling(state) && (period_cnt != TW'(THROTTLE_PERIOD - 1)))
         period_nx = period_cnt + TW'(1);
   end

   always_comb begin
      level_nx    = state_level(state_nx);
      flush_nx    = (state_nx == ST_FLUSH);
      stall_nx    = (state_nx == ST_FLUSH);
      throttle_nx = (state_nx == state) && is_throttling(state) && (period_cnt == '0);
      recovery_nx = recovery_count;
      if (flush_done && (recovery_count != 8'hFF)) recovery_nx = recovery_count + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flush_req      <= 1'b0;
         stall_pipeline <= 1'b0;
         throttle_stall <= 1'b0;
         chaos_level    <= LVL_NORMAL;
         recovery_count <= '0;
      end else begin
         flush_req      <= flush_nx;
         stall_pipeline <= stall_nx;
         throttle_stall <= throttle_nx;
         chaos_level    <= level_nx;
         recovery_count <= recovery_nx;
      end
   end

endmodule
